// File: rtl/dpram32x32_arb_pkg.sv
// Shared defaults and types for the dual-port RAM arbiter.
//   NUM_REQ_DEF  : default number of requesters
//   ADDR_W_DEF   : default RAM word-address width
//   DATA_W_DEF   : default RAM word width
//   port_state_t : per-RAM-port access FSM state
package dpram32x32_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic {
        READY = 1'b0,
        PULSE = 1'b1
    } port_state_t;

endpackage

// File: rtl/dpram32x32_arb_port.sv
// One RAM port: access FSM, registered active-low strobes and read capture.
//   clk, rst         : clock, synchronous active-high reset
//   issue, iss_*     : access handed over by the arbiter (only while ready)
//   ready            : port can accept an access this cycle
//   pulse_wr         : a write is in its strobe cycle (address on a)
//   cap_en, cap_id   : read data on the RAM output is valid this cycle, owner id
//   a, ceb, csb, web, oeb, i : RAM address / strobes / write data
//
// state | meaning
// ------+-----------------------------------------------------------
// READY | strobes idle or in latch phase; may accept a new access
// PULSE | CEB/CSB low for the issued access; back to READY next cycle
module dpram32x32_arb_port
    import dpram32x32_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] iss_wdata,
    input  logic [ID_W-1:0]   iss_id,
    output logic              ready,
    output logic              pulse_wr,
    output logic              cap_en,
    output logic [ID_W-1:0]   cap_id,
    output logic [ADDR_W-1:0] a,
    output logic              ceb,
    output logic              csb,
    output logic              web,
    output logic              oeb,
    output logic [DATA_W-1:0] i
);

    port_state_t       state, state_nxt;
    logic              ceb_d, csb_d, web_d, oeb_d;
    logic [ADDR_W-1:0] a_d;
    logic [DATA_W-1:0] i_d;
    logic              rd_q;
    logic [ID_W-1:0]   id_q;

    always_ff @(posedge clk) begin
        if (rst) state <= READY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            READY:   if (issue) state_nxt = PULSE;
            PULSE:   state_nxt = READY;
            default: state_nxt = READY;
        endcase
    end

    // Strobe next-values. The cycle after PULSE raises CEB (RAM latches) while
    // address, WEB, data and OEB stay put so the RAM sees a clean edge.
    always_comb begin
        ready    = (state == READY);
        pulse_wr = (state == PULSE) && !web;
        ceb_d    = 1'b1;
        csb_d    = 1'b1;
        web_d    = 1'b1;
        oeb_d    = 1'b1;
        a_d      = a;
        i_d      = i;
        if (state == PULSE) begin
            web_d = web;
            oeb_d = oeb;
        end else if (issue) begin
            ceb_d = 1'b0;
            csb_d = 1'b0;
            a_d   = iss_addr;
            web_d = !iss_we;
            oeb_d = iss_we;
            if (iss_we) i_d = iss_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ceb    <= 1'b1;
            csb    <= 1'b1;
            web    <= 1'b1;
            oeb    <= 1'b1;
            a      <= '0;
            i      <= '0;
            rd_q   <= 1'b0;
            id_q   <= '0;
            cap_en <= 1'b0;
            cap_id <= '0;
        end else begin
            ceb <= ceb_d;
            csb <= csb_d;
            web <= web_d;
            oeb <= oeb_d;
            a   <= a_d;
            i   <= i_d;
            if (ready && issue) begin
                rd_q <= !iss_we;
                id_q <= iss_id;
            end
            // A reset during PULSE clears this, which is what drops the rvalid.
            cap_en <= (state == PULSE) && rd_q;
            cap_id <= id_q;
        end
    end

endmodule

// File: rtl/dpram32x32_arb.sv
// Round-robin arbiter sharing a dual-port RAM between NUM_REQ requesters.
//   clk, rst              : clock, synchronous active-high reset
//   req, we, addr, wdata  : per-requester request, held until gnt
//   gnt                   : combinational one-cycle grant
//   rvalid, rdata         : read return, 3 cycles after grant; rdata held
//   A1/A2, CEB*, CSB*, WEB*, OEB*, I1/I2, O1/O2 : RAM port 1 / port 2 pins
module dpram32x32_arb
    import dpram32x32_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [NUM_REQ-1:0][DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]              A1,
    output logic [ADDR_W-1:0]              A2,
    output logic                           CEB1,
    output logic                           CEB2,
    output logic                           CSB1,
    output logic                           CSB2,
    output logic                           WEB1,
    output logic                           WEB2,
    output logic                           OEB1,
    output logic                           OEB2,
    output logic [DATA_W-1:0]              I1,
    output logic [DATA_W-1:0]              I2,
    input  logic [DATA_W-1:0]              O1,
    input  logic [DATA_W-1:0]              O2
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [RR_W-1:0] idx_t;
    typedef logic [RR_W:0]   sum_t;

    idx_t rr, rr_nxt;
    logic rdy1, rdy2, pwr1, pwr2, cap1, cap2;
    idx_t cid1, cid2;
    logic iss1, iss2;
    idx_t id1, id2;

    always_comb begin
        logic have0, have1, blk;
        idx_t w0, w1, idx, last;
        sum_t sum;
        have0  = 1'b0;
        have1  = 1'b0;
        blk    = 1'b0;
        w0     = '0;
        w1     = '0;
        idx    = '0;
        last   = '0;
        sum    = '0;
        iss1   = 1'b0;
        iss2   = 1'b0;
        id1    = '0;
        id2    = '0;
        gnt    = '0;
        rr_nxt = rr;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = sum_t'(rr) + sum_t'(k);
                if (sum >= sum_t'(NUM_REQ)) sum = sum - sum_t'(NUM_REQ);
                idx = sum[RR_W-1:0];
                // A write may not start while the other port is still strobing
                // a write to the same word; the two write windows would overlap.
                blk = we[idx] && ((pwr1 && A1 == addr[idx]) || (pwr2 && A2 == addr[idx]));
                if (req[idx] && !blk) begin
                    if (!have0) begin
                        have0 = 1'b1;
                        w0    = idx;
                    end else if (!have1 && !(addr[idx] == addr[w0] && (we[idx] || we[w0]))) begin
                        have1 = 1'b1;
                        w1    = idx;
                    end
                end
            end
            if (have0) begin
                if (rdy1) begin
                    iss1 = 1'b1;
                    id1  = w0;
                    if (rdy2 && have1) begin
                        iss2 = 1'b1;
                        id2  = w1;
                    end
                end else if (rdy2) begin
                    iss2 = 1'b1;
                    id2  = w0;
                end
            end
            if (iss1) gnt[id1] = 1'b1;
            if (iss2) gnt[id2] = 1'b1;
            if (iss1 || iss2) begin
                last   = (iss1 && iss2) ? w1 : w0;
                rr_nxt = (last == idx_t'(NUM_REQ - 1)) ? '0 : last + idx_t'(1);
            end
        end
    end

    dpram32x32_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(RR_W)) u_port1 (
        .clk       (clk),
        .rst       (rst),
        .issue     (iss1),
        .iss_we    (we[id1]),
        .iss_addr  (addr[id1]),
        .iss_wdata (wdata[id1]),
        .iss_id    (id1),
        .ready     (rdy1),
        .pulse_wr  (pwr1),
        .cap_en    (cap1),
        .cap_id    (cid1),
        .a         (A1),
        .ceb       (CEB1),
        .csb       (CSB1),
        .web       (WEB1),
        .oeb       (OEB1),
        .i         (I1)
    );

    dpram32x32_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(RR_W)) u_port2 (
        .clk       (clk),
        .rst       (rst),
        .issue     (iss2),
        .iss_we    (we[id2]),
        .iss_addr  (addr[id2]),
        .iss_wdata (wdata[id2]),
        .iss_id    (id2),
        .ready     (rdy2),
        .pulse_wr  (pwr2),
        .cap_en    (cap2),
        .cap_id    (cid2),
        .a         (A2),
        .ceb       (CEB2),
        .csb       (CSB2),
        .web       (WEB2),
        .oeb       (OEB2),
        .i         (I2)
    );

    // A requester holds at most one grant per cycle, so both ports never
    // return data for the same requester in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr     <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rr <= rr_nxt;
            for (int r = 0; r < NUM_REQ; r++) begin
                rvalid[r] <= (cap1 && cid1 == idx_t'(r)) || (cap2 && cid2 == idx_t'(r));
                if (cap1 && cid1 == idx_t'(r))      rdata[r] <= O1;
                else if (cap2 && cid2 == idx_t'(r)) rdata[r] <= O2;
            end
        end
    end

endmodule

// File: tb/tb_dpram32x32_arb.sv
module tb_dpram32x32_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req, we;
    logic [3:0][4:0]  addr;
    logic [3:0][31:0] wdata;
    logic [3:0]       gnt, rvalid;
    logic [3:0][31:0] rdata;
    logic [4:0]       A1, A2;
    logic             CEB1, CEB2, CSB1, CSB2, WEB1, WEB2, OEB1, OEB2;
    logic [31:0]      I1, I2, O1, O2;

    always #5 clk = ~clk;

    dpram32x32_arb dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .A1(A1), .A2(A2), .CEB1(CEB1), .CEB2(CEB2), .CSB1(CSB1), .CSB2(CSB2),
        .WEB1(WEB1), .WEB2(WEB2), .OEB1(OEB1), .OEB2(OEB2),
        .I1(I1), .I2(I2), .O1(O1), .O2(O2)
    );

    // RAM model: an access completes on the edge that ends its CEB-low cycle.
    logic [31:0] ram [32];
    initial for (int k = 0; k < 32; k++) ram[k] = 32'h0;
    always @(posedge clk) begin
        if (!CEB1 && !CSB1) begin
            if (!WEB1) ram[A1] <= I1;
            else       O1 <= ram[A1];
        end
        if (!CEB2 && !CSB2) begin
            if (!WEB2) ram[A2] <= I2;
            else       O2 <= ram[A2];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int gcount [4];
    logic [31:0] sh [32];

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: grants push expected read data, rvalid pops and compares.
    initial begin
        for (int k = 0; k < 32; k++) sh[k] = 32'h0;
        for (int k = 0; k < 4; k++) gcount[k] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int r = 0; r < 4; r++) begin
                if (rvalid[r]) begin
                    int k;
                    k = -1;
                    for (int j = 0; j < q.size(); j++)
                        if (k < 0 && q[j].id == r) k = j;
                    if (k < 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rvalid_unexpected: requester %0d got rvalid with nothing outstanding", r);
                    end else begin
                        chk("sb_rdata", rdata[r], q[k].data);
                        chk("sb_latency", 32'(cyc - q[k].cyc), 32'd3);
                        q.delete(k);
                    end
                end
            end
            if (rst) q.delete();
            if (gnt != 4'b0) begin
                chk("gnt_without_req", 32'(gnt & ~(rst ? 4'b0 : req)), 32'd0);
                for (int r = 0; r < 4; r++) begin
                    if (gnt[r]) begin
                        gcount[r]++;
                        if (we[r]) sh[addr[r]] = wdata[r];
                        else       q.push_back('{r, sh[addr[r]], cyc});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", 32'({CEB1, CSB1, WEB1, OEB1, CEB2, CSB2, WEB2, OEB2}), 32'hFF);
        chk("rst_addr", 32'({A1, A2}), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata0", rdata[0], 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic issue(input int r, input logic w, input logic [4:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = d;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            got = gnt[r];
        end
        chk("gnt_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1 req[r] = 1'b0;
    endtask

    typedef struct {
        int          r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vec [9];

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        vec[0] = '{0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
        vec[1] = '{0, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
        vec[2] = '{3, 1'b1, 5'd31, 32'hA5A50001, 32'h0};
        vec[3] = '{2, 1'b1, 5'd0,  32'h12345678, 32'h0};
        vec[4] = '{3, 1'b0, 5'd31, 32'h0,        32'hA5A50001};
        vec[5] = '{2, 1'b0, 5'd0,  32'h0,        32'h12345678};
        vec[6] = '{1, 1'b1, 5'd5,  32'hCAFEF00D, 32'h0};
        vec[7] = '{1, 1'b0, 5'd5,  32'h0,        32'hCAFEF00D};
        vec[8] = '{0, 1'b0, 5'd5,  32'h0,        32'hCAFEF00D};

        do_reset();

        for (int v = 0; v < 9; v++) begin
            issue(vec[v].r, vec[v].w, vec[v].a, vec[v].d);
            if (!vec[v].w) begin
                repeat (3) @(negedge clk);
                chk("vec_rvalid", 32'(rvalid[vec[v].r]), 32'd1);
                chk("vec_rdata", rdata[vec[v].r], vec[v].exp_rd);
                @(posedge clk);
                #1;
            end
        end

        // dual issue from rr=0
        do_reset();
        we = '0; addr[1] = 5'd3; addr[2] = 5'd7; req = 4'b0110;
        @(negedge clk);
        chk("dual_gnt", 32'(gnt), 32'b0110);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        chk("dual_A1", 32'(A1), 32'd3);
        chk("dual_A2", 32'(A2), 32'd7);
        chk("dual_pulse1", 32'({CEB1, CSB1, OEB1, WEB1}), 32'b0001);
        chk("dual_pulse2", 32'({CEB2, CSB2, OEB2, WEB2}), 32'b0001);
        @(negedge clk);
        chk("dual_latch1", 32'({CEB1, CSB1, OEB1, WEB1}), 32'b1101);
        chk("dual_latch_A1", 32'(A1), 32'd3);
        @(negedge clk);
        chk("dual_rvalid", 32'(rvalid), 32'b0110);
        @(posedge clk);
        #1;

        // same-address write conflict
        do_reset();
        addr[0] = 5'd9; addr[1] = 5'd9;
        wdata[0] = 32'h11110000; wdata[1] = 32'h22220000;
        we = 4'b0011; req = 4'b0011;
        @(negedge clk);
        chk("conf_gnt_g", 32'(gnt), 32'b0001);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        chk("conf_gnt_g1", 32'(gnt), 32'b0000);
        @(negedge clk);
        chk("conf_gnt_g2", 32'(gnt), 32'b0010);
        @(posedge clk);
        #1 req[1] = 1'b0; we = '0;
        repeat (3) @(negedge clk);
        chk("conf_ram9", ram[9], 32'h22220000);
        @(posedge clk);
        #1;
        issue(2, 1'b0, 5'd9, 32'h0);
        repeat (3) @(negedge clk);
        chk("conf_readback", rdata[2], 32'h22220000);
        @(posedge clk);
        #1;

        // fairness: all four reading continuously
        do_reset();
        for (int r = 0; r < 4; r++) begin
            gcount[r] = 0;
            addr[r] = 5'(r * 4 + 2);
        end
        we = '0; req = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) chk("fair_gnt0", 32'(gnt), 32'b0011);
            if (c == 1) chk("fair_gnt1", 32'(gnt), 32'b0000);
            if (c == 2) chk("fair_gnt2", 32'(gnt), 32'b1100);
            if (c == 4) chk("fair_wrap", 32'(gnt), 32'b0011);
        end
        @(posedge clk);
        #1 req = '0;
        for (int r = 0; r < 4; r++) chk("fair_count", 32'(gcount[r]), 32'd4);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;

        // reset during the PULSE cycle of a read
        addr[2] = 5'd0; we = '0; req = 4'b0100;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'b0100);
        @(posedge clk);
        #1 req = '0; rst = 1'b1;
        @(negedge clk);
        chk("mid_pulse_ceb1", 32'(CEB1), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_strobes", 32'({CEB1, CSB1, WEB1, OEB1, CEB2, CSB2, WEB2, OEB2}), 32'hFF);
        chk("mid_rvalid", 32'(rvalid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_rvalid", 32'(rvalid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram32x32_arb.md
DPRAM32X32_ARB -- requirements
Module: dpram32x32_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter ADDR_W, default 5, RAM address width.
REQ-003 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester access request.
REQ-007 SHALL have port we  input  NUM_REQ  per-requester write (1) / read (0).
REQ-008 SHALL have port addr  input  NUM_REQ x ADDR_W  per-requester word address.
REQ-009 SHALL have port wdata  input  NUM_REQ x DATA_W  per-requester write data.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-cycle grant pulse, combinational.
REQ-011 SHALL have port rvalid  output  NUM_REQ  one-cycle read-data-valid pulse.
REQ-012 SHALL have port rdata  output  NUM_REQ x DATA_W  per-requester read data, held until next rvalid for that requester.
REQ-013 SHALL have ports A1/A2  output  ADDR_W  RAM port 1/2 address.
REQ-014 SHALL have ports CEB1/CEB2, CSB1/CSB2, WEB1/WEB2, OEB1/OEB2  output  1 each  RAM active-low strobes, registered.
REQ-015 SHALL have ports I1/I2  output  DATA_W  and O1/O2  input  DATA_W  RAM write/read data.

Function
REQ-016 Requester SHALL hold req/we/addr/wdata stable from assertion until the cycle gnt is high; gnt only while req high.
REQ-017 Each RAM port SHALL run a two-state FSM READY -> PULSE (on issue) -> READY (unconditional); one access per port per 2 cycles.
REQ-018 In issue cycle G, up to two requesters SHALL be granted in round-robin order starting at pointer rr; first winner to port 1 if READY, next to the other READY port.
REQ-019 rr SHALL advance to (last granted index + 1) mod NUM_REQ after any grant; unchanged otherwise.
REQ-020 Two candidates with equal addr where at least one is a write SHALL NOT both be granted; the later in round-robin order waits.
REQ-021 In cycle G+1 (PULSE) the port SHALL drive CEBn=0, CSBn=0, An=addr, WEBn=~we, In=wdata (writes), OEBn=0 for reads, 1 for writes.
REQ-022 In cycle G+2 the port SHALL drive CEBn=1 (rising edge latches the RAM), hold An/WEBn/In, keep OEBn=0 for reads, CSBn=1.
REQ-023 For reads, On SHALL be captured at the end of G+2; rvalid[r] high and rdata[r] updated in G+3 (3-cycle grant-to-data latency).
REQ-024 Writes SHALL produce no rvalid; a read granted the cycle after a write to the same address SHALL return the new data.
REQ-025 Idle port outputs: CEBn=1, CSBn=1, WEBn=1, OEBn=1, An and In hold last value.
REQ-026 No requester SHALL starve: with continuous requests each is granted within NUM_REQ issue opportunities.

Reset
REQ-027 On rst sampled high: CEBn=1, CSBn=1, WEBn=1, OEBn=1, An=0, In=0, gnt=0, rvalid=0, rdata=0, rr=0, both FSMs READY.
REQ-028 An access in PULSE when rst is sampled SHALL still complete in RAM (write may land); its rvalid SHALL be suppressed; no grant while rst high.

Structure
REQ-029 Package dpram32x32_arb_pkg SHALL hold NUM_REQ, ADDR_W, DATA_W defaults and the port FSM state enum (READY, PULSE).
REQ-030 Sub-module dpram32x32_arb_port SHALL implement one port FSM, strobe registers and read capture; instantiated twice.

Verification
REQ-031 Reset: rst high 2 cycles -> all CEB/CSB/WEB/OEB = 1, A=0, gnt=0, rvalid=0.
REQ-032 Single write/read: req0 write addr 5 data 0xDEADBEEF, then read addr 5 -> rvalid[0] 3 cycles after read gnt, rdata[0]=0xDEADBEEF.
REQ-033 Dual issue: req1 read addr 3, req2 read addr 7 same cycle, rr=0 -> both granted, req1 on port 1, req2 on port 2.
REQ-034 Conflict: req0 and req1 write addr 9 same cycle, rr=0 -> gnt[0] first, gnt[1] two cycles later, final RAM[9]=req1 data.
REQ-035 Fairness: all four requesters reading continuously for 16 cycles -> each granted 4 times, rr wraps 3 -> 0.
REQ-036 Reset mid-read: rst asserted in PULSE cycle of read -> no rvalid, all strobes 1 next cycle.
